vli_coef_decoder: RTL and testbench

- Sequential, parametrised successor to the combinational VLI decoder.
- Accepts entropy-decoded tokens (DC flag, run, size, VLI symbol, channel) on a valid/ready stream.
- Emits one signed coefficient per cycle with its zigzag index: expands zero runs, ZRL and EOB fill, and applies per-channel DC prediction.
- Sits between the Huffman decoder and the dequantiser/IDCT front-end.

---
 rtl/vli_coef_decoder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_vli_coef_decoder.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vli_coef_decoder.sv
// Token-to-coefficient expander: decodes VLI symbols, expands zero runs, ZRL and EOB fill.
// Define VLI_DC_PRED_EN to build the per-channel DC predictors with saturation and dc_clear.
module vli_coef_decoder #(
    parameter int MAX_SIZE = 11,
    parameter int COEF_W   = 12,
    parameter int NUM_CH   = 3,
    parameter int CH_W     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_dc,
    input  logic [3:0]               in_run,
    input  logic [3:0]               in_size,
    input  logic [MAX_SIZE-1:0]      in_symbol,
    input  logic [CH_W-1:0]          in_ch,
    input  logic                     dc_clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] out_coef,
    output logic [5:0]               out_idx,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last,
    output logic                     err
);

    localparam int VW = MAX_SIZE + 1;

    typedef enum logic [1:0] {
        S_ACCEPT,
        S_ZERO,
        S_VAL,
        S_FILL
    } state_t;

    state_t state_q, state_d;
    logic [5:0]               idx_q, idx_d;
    logic [4:0]               rem_q, rem_d;
    logic                     zrl_q, zrl_d;
    logic signed [COEF_W-1:0] val_q, val_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [COEF_W-1:0] out_coef_q, out_coef_d;
    logic [5:0]               out_idx_q, out_idx_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic                     out_last_q, out_last_d;
    logic                     err_q, err_d;

    logic                     advance;
    logic                     size_big;
    logic [3:0]               size_eff;
    logic [MAX_SIZE-1:0]      mask;
    logic [MAX_SIZE-1:0]      masked;
    logic                     msb;
    logic signed [VW-1:0]     value;
    logic signed [COEF_W-1:0] value_ext;
    logic                     ch_bad;
    logic [CH_W-1:0]          ch_eff;
    logic signed [COEF_W-1:0] dc_coef;
    logic                     dc_upd;

    logic                     emit_go;
    logic [5:0]               emit_idx;
    logic signed [COEF_W-1:0] emit_coef;
    logic                     zb_go;
    logic [4:0]               zb_cnt;
    logic                     zb_trail;

    // Nothing moves while a held output beat is still waiting for downstream.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = (state_q == S_ACCEPT) && advance;

    always_comb begin
        size_big = int'(in_size) > MAX_SIZE;
        size_eff = size_big ? 4'(MAX_SIZE) : in_size;
        mask     = '0;
        masked   = '0;
        msb      = 1'b0;
        for (int i = 0; i < MAX_SIZE; i++) begin
            if (i < int'(size_eff)) begin
                mask[i]   = 1'b1;
                masked[i] = in_symbol[i];
            end
            if (i == int'(size_eff) - 1) begin
                msb = in_symbol[i];
            end
        end
        // A clear top bit encodes a negative value offset by 2^size - 1.
        value     = msb ? {1'b0, masked} : ({1'b0, masked} - {1'b0, mask});
        value_ext = COEF_W'(value);
        ch_bad    = int'(in_ch) >= NUM_CH;
        ch_eff    = ch_bad ? '0 : in_ch;
    end

`ifdef VLI_DC_PRED_EN
    logic signed [COEF_W-1:0] pred_q [NUM_CH];
    logic signed [COEF_W-1:0] pred_d [NUM_CH];
    logic signed [COEF_W-1:0] pred_base;
    logic signed [COEF_W:0]   dc_sum;

    always_comb begin
        pred_base = dc_clear ? '0 : pred_q[ch_eff];
        dc_sum    = (COEF_W+1)'(pred_base) + (COEF_W+1)'(value);
        if (dc_sum[COEF_W] != dc_sum[COEF_W-1]) begin
            dc_coef = dc_sum[COEF_W] ? {1'b1, {(COEF_W-1){1'b0}}} : {1'b0, {(COEF_W-1){1'b1}}};
        end else begin
            dc_coef = dc_sum[COEF_W-1:0];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pred_d[i] = dc_clear ? '0 : pred_q[i];
            if (dc_upd && ch_eff == CH_W'(i)) begin
                pred_d[i] = dc_coef;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                pred_q[i] <= '0;
            end else begin
                pred_q[i] <= pred_d[i];
            end
        end
    end
`else
    logic unused_pred_sigs;
    assign unused_pred_sigs = dc_clear ^ dc_upd;
    assign dc_coef          = value_ext;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        zrl_d       = zrl_q;
        val_d       = val_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q;
        out_coef_d  = out_coef_q;
        out_idx_d   = out_idx_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        dc_upd      = 1'b0;
        emit_go     = 1'b0;
        emit_idx    = idx_q;
        emit_coef   = '0;
        zb_go       = 1'b0;
        zb_cnt      = '0;
        zb_trail    = 1'b0;
        if (advance) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            case (state_q)
                S_ACCEPT: begin
                    if (in_valid) begin
                        ch_d = ch_eff;
                        if (size_big || ch_bad) err_d = 1'b1;
                        if (in_dc) begin
                            if (idx_q != 6'd0) err_d = 1'b1;
                            dc_upd    = 1'b1;
                            emit_go   = 1'b1;
                            emit_idx  = 6'd0;
                            emit_coef = dc_coef;
                        end else if (idx_q == 6'd0) begin
                            err_d = 1'b1;
                        end else if (size_eff == 4'd0 && in_run == 4'd0) begin
                            emit_go = 1'b1;
                            if (idx_q != 6'd63) state_d = S_FILL;
                        end else if (size_eff == 4'd0 && in_run == 4'd15) begin
                            zb_go  = 1'b1;
                            zb_cnt = 5'd16;
                        end else if (in_run != 4'd0) begin
                            zb_go    = 1'b1;
                            zb_cnt   = {1'b0, in_run};
                            zb_trail = 1'b1;
                            val_d    = value_ext;
                        end else begin
                            emit_go   = 1'b1;
                            emit_coef = value_ext;
                        end
                    end
                end
                S_ZERO: begin
                    zb_go    = 1'b1;
                    zb_cnt   = rem_q;
                    zb_trail = !zrl_q;
                end
                S_VAL: begin
                    emit_go   = 1'b1;
                    emit_coef = val_q;
                    state_d   = S_ACCEPT;
                end
                S_FILL: begin
                    emit_go = 1'b1;
                    if (idx_q == 6'd63) state_d = S_ACCEPT;
                end
                default: state_d = S_ACCEPT;
            endcase
            // One zero beat; anything still owed after idx 63 is an overrun and is dropped.
            if (zb_go) begin
                emit_go = 1'b1;
                rem_d   = zb_cnt - 5'd1;
                zrl_d   = !zb_trail;
                if (idx_q == 6'd63) begin
                    if (rem_d != 5'd0 || zb_trail) err_d = 1'b1;
                    state_d = S_ACCEPT;
                end else if (rem_d == 5'd0) begin
                    state_d = zb_trail ? S_VAL : S_ACCEPT;
                end else begin
                    state_d = S_ZERO;
                end
            end
            if (emit_go) begin
                out_valid_d = 1'b1;
                out_coef_d  = emit_coef;
                out_idx_d   = emit_idx;
                out_ch_d    = ch_d;
                out_last_d  = (emit_idx == 6'd63);
                idx_d       = emit_idx + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_ACCEPT;
            idx_q       <= '0;
            rem_q       <= '0;
            zrl_q       <= 1'b0;
            val_q       <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_coef_q  <= '0;
            out_idx_q   <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            zrl_q       <= zrl_d;
            val_q       <= val_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_coef_q  <= out_coef_d;
            out_idx_q   <= out_idx_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_coef  = out_coef_q;
    assign out_idx   = out_idx_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vli_coef_decoder.sv
// Directed bench for vli_coef_decoder: tokens in, recorded coefficient beats checked per scenario.
module tb_vli_coef_decoder;
    localparam int MAX_SIZE = 11;
    localparam int COEF_W   = 12;
    localparam int CH_W     = 2;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     in_dc = 1'b0;
    logic [3:0]               in_run = '0;
    logic [3:0]               in_size = '0;
    logic [MAX_SIZE-1:0]      in_symbol = '0;
    logic [CH_W-1:0]          in_ch = '0;
    logic                     dc_clear = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [COEF_W-1:0] out_coef;
    logic [5:0]               out_idx;
    logic [CH_W-1:0]          out_ch;
    logic                     out_last;
    logic                     err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [COEF_W-1:0]        exp_q[$];
    logic signed [COEF_W-1:0] mon_coef[$];
    logic [5:0]               mon_idx[$];
    logic                     mon_last[$];
    logic [CH_W-1:0]          mon_ch[$];

    vli_coef_decoder #(
        .MAX_SIZE(MAX_SIZE),
        .COEF_W(COEF_W),
        .NUM_CH(3),
        .CH_W(CH_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_dc(in_dc),
        .in_run(in_run),
        .in_size(in_size),
        .in_symbol(in_symbol),
        .in_ch(in_ch),
        .dc_clear(dc_clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_coef(out_coef),
        .out_idx(out_idx),
        .out_ch(out_ch),
        .out_last(out_last),
        .err(err)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Beat recorder: a beat transfers on the posedge following a negedge with valid && ready.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            mon_coef.push_back(out_coef);
            mon_idx.push_back(out_idx);
            mon_last.push_back(out_last);
            mon_ch.push_back(out_ch);
        end
    end

    // Driver tasks
    task automatic clear_mon();
        mon_coef.delete();
        mon_idx.delete();
        mon_last.delete();
        mon_ch.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        in_valid  = 1'b0;
        dc_clear  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic send(input logic dc, input logic [3:0] run, input logic [3:0] size,
                        input logic [MAX_SIZE-1:0] sym, input logic [CH_W-1:0] ch, input logic clr);
        bit acc;
        acc       = 1'b0;
        in_valid  = 1'b1;
        in_dc     = dc;
        in_run    = run;
        in_size   = size;
        in_symbol = sym;
        in_ch     = ch;
        dc_clear  = clr;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_dc    = 1'b0;
        dc_clear = 1'b0;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_accept: in_ready=%0b, required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic wait_beats(input int n);
        for (int k = 0; k < 3000 && mon_coef.size() < n; k++) @(negedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (mon_coef.size() < n) begin
            n_fail++;
            $display("FAIL wait_beats: got %0d beats, required %0d", mon_coef.size(), n);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: %0b, required 0", out_valid); end
        n_checks++; if (out_coef !== 12'sd0) begin n_fail++; $display("FAIL reset_coef: %0d, required 0", out_coef); end
        n_checks++; if (out_idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx: %0d, required 0", out_idx); end
        n_checks++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch: %0d, required 0", out_ch); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: %0b, required 0", out_last); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: %0b, required 0", err); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: %0b, required 1", in_ready); end
        @(posedge clk);
        #1;
        clear_mon();
    endtask

    task automatic test_dc_eob();
        clear_mon();
        send(1'b1, 4'd0, 4'd3, 11'b111, 2'd0, 1'b0);
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(64);
        exp_q.delete();
        exp_q.push_back(12'd7);
        while (exp_q.size() < 64) exp_q.push_back(12'd0);
        for (int i = 0; i < 64 && i < mon_coef.size(); i++) begin
            n_checks++;
            if (mon_coef[i] !== exp_q[i] || mon_idx[i] !== 6'(i) || mon_last[i] !== (i == 63) || mon_ch[i] !== 2'd0) begin
                n_fail++;
                $display("FAIL dc_eob_beat%0d: coef=%0d idx=%0d last=%0b ch=%0d, required coef=%0d idx=%0d last=%0b ch=0",
                         i, mon_coef[i], mon_idx[i], mon_last[i], mon_ch[i], $signed(exp_q[i]), i, i == 63);
            end
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dc_eob_err: %0b, required 0", err); end
    endtask

    task automatic test_dc_pred();
        logic signed [COEF_W-1:0] e0;
        logic signed [COEF_W-1:0] e1;
`ifdef VLI_DC_PRED_EN
        e0 = 12'sd6;
`else
        e0 = -12'sd1;
`endif
        e1 = -12'sd2;
        clear_mon();
        send(1'b1, 4'd0, 4'd1, 11'd0, 2'd0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_coef !== e0 || out_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL dc_pred_ch0: valid=%0b coef=%0d idx=%0d, required valid=1 coef=%0d idx=0", out_valid, out_coef, out_idx, e0);
        end
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(64);
        clear_mon();
        send(1'b1, 4'd0, 4'd2, 11'b01, 2'd1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_coef !== e1 || out_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL dc_pred_ch1: valid=%0b coef=%0d ch=%0d, required valid=1 coef=%0d ch=1", out_valid, out_coef, out_ch, e1);
        end
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd1, 1'b0);
        wait_beats(64);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dc_pred_err: %0b, required 0", err); end
    endtask

    task automatic test_ac_run();
        do_reset();
        send(1'b1, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        send(1'b0, 4'd2, 4'd10, 11'd0, 2'd0, 1'b0);
        send(1'b0, 4'd0, 4'd11, 11'd0, 2'd0, 1'b0);
        send(1'b0, 4'd0, 4'd4, 11'h7FA, 2'd0, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ac_run_err_before: %0b, required 0", err); end
        send(1'b0, 4'd0, 4'd15, 11'h7FF, 2'd0, 1'b0);
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(64);
        exp_q.delete();
        exp_q.push_back(12'd0);
        exp_q.push_back(12'd0);
        exp_q.push_back(12'd0);
        exp_q.push_back(-12'sd1023);
        exp_q.push_back(-12'sd2047);
        exp_q.push_back(12'd10);
        exp_q.push_back(12'd2047);
        while (exp_q.size() < 64) exp_q.push_back(12'd0);
        for (int i = 0; i < 64 && i < mon_coef.size(); i++) begin
            n_checks++;
            if (mon_coef[i] !== exp_q[i] || mon_idx[i] !== 6'(i) || mon_last[i] !== (i == 63)) begin
                n_fail++;
                $display("FAIL ac_run_beat%0d: coef=%0d idx=%0d last=%0b, required coef=%0d idx=%0d last=%0b",
                         i, mon_coef[i], mon_idx[i], mon_last[i], $signed(exp_q[i]), i, i == 63);
            end
        end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ac_run_err_oversize: %0b, required 1", err); end
    endtask

    task automatic test_zrl();
        do_reset();
        send(1'b1, 4'd0, 4'd0, 11'd0, 2'd2, 1'b0);
        send(1'b0, 4'd15, 4'd0, 11'd0, 2'd2, 1'b0);
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd2, 1'b0);
        wait_beats(64);
        exp_q.delete();
        while (exp_q.size() < 64) exp_q.push_back(12'd0);
        for (int i = 0; i < 64 && i < mon_coef.size(); i++) begin
            n_checks++;
            if (mon_coef[i] !== exp_q[i] || mon_idx[i] !== 6'(i) || mon_last[i] !== (i == 63) || mon_ch[i] !== 2'd2) begin
                n_fail++;
                $display("FAIL zrl_beat%0d: coef=%0d idx=%0d last=%0b ch=%0d, required coef=0 idx=%0d last=%0b ch=2",
                         i, mon_coef[i], mon_idx[i], mon_last[i], mon_ch[i], i, i == 63);
            end
        end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL zrl_err: %0b, required 0", err); end
    endtask

    task automatic test_overrun();
        do_reset();
        send(1'b1, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        for (int z = 0; z < 3; z++) send(1'b0, 4'd15, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(49);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL overrun_err_before: %0b, required 0", err); end
        send(1'b0, 4'd15, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(64);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (mon_coef.size() !== 64) begin n_fail++; $display("FAIL overrun_beats: %0d, required 64", mon_coef.size()); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL overrun_err: %0b, required 1", err); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL overrun_in_ready: %0b, required 1", in_ready); end
        for (int i = 0; i < 64 && i < mon_coef.size(); i++) begin
            n_checks++;
            if (mon_coef[i] !== 12'sd0 || mon_idx[i] !== 6'(i) || mon_last[i] !== (i == 63)) begin
                n_fail++;
                $display("FAIL overrun_beat%0d: coef=%0d idx=%0d last=%0b, required coef=0 idx=%0d last=%0b",
                         i, mon_coef[i], mon_idx[i], mon_last[i], i, i == 63);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [COEF_W-1:0] s_coef;
        logic [5:0]               s_idx;
        do_reset();
        send(1'b1, 4'd0, 4'd0, 11'd0, 2'd1, 1'b0);
        send(1'b0, 4'd10, 4'd2, 11'b11, 2'd1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        s_coef = out_coef;
        s_idx  = out_idx;
        n_checks++;
        if (out_valid !== 1'b1 || s_idx !== 6'd3) begin
            n_fail++;
            $display("FAIL bp_hold_start: valid=%0b idx=%0d, required valid=1 idx=3", out_valid, s_idx);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_idx !== s_idx || out_coef !== s_coef || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_stable%0d: valid=%0b idx=%0d coef=%0d in_ready=%0b, required valid=1 idx=%0d coef=%0d in_ready=0",
                         k, out_valid, out_idx, out_coef, in_ready, s_idx, s_coef);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd1, 1'b0);
        wait_beats(64);
        exp_q.delete();
        while (exp_q.size() < 64) exp_q.push_back(12'd0);
        exp_q[11] = 12'd3;
        for (int i = 0; i < 64 && i < mon_coef.size(); i++) begin
            n_checks++;
            if (mon_coef[i] !== exp_q[i] || mon_idx[i] !== 6'(i) || mon_last[i] !== (i == 63) || mon_ch[i] !== 2'd1) begin
                n_fail++;
                $display("FAIL bp_beat%0d: coef=%0d idx=%0d last=%0b ch=%0d, required coef=%0d idx=%0d last=%0b ch=1",
                         i, mon_coef[i], mon_idx[i], mon_last[i], mon_ch[i], $signed(exp_q[i]), i, i == 63);
            end
        end
    endtask

    task automatic test_dc_clear();
        logic signed [COEF_W-1:0] e_bad;
`ifdef VLI_DC_PRED_EN
        e_bad = 12'sd2;
`else
        e_bad = 12'sd1;
`endif
        do_reset();
        send(1'b1, 4'd0, 4'd3, 11'b111, 2'd0, 1'b0);
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(64);
        send(1'b1, 4'd0, 4'd0, 11'd0, 2'd0, 1'b1);
        n_checks++; if (out_coef !== 12'sd0) begin n_fail++; $display("FAIL dc_clear_same_cycle: coef=%0d, required 0", out_coef); end
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(128);
        send(1'b1, 4'd0, 4'd1, 11'd1, 2'd0, 1'b0);
        n_checks++; if (out_coef !== 12'sd1) begin n_fail++; $display("FAIL dc_clear_after: coef=%0d, required 1", out_coef); end
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(192);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL dc_clear_err: %0b, required 0", err); end
        send(1'b1, 4'd0, 4'd1, 11'd1, 2'd3, 1'b0);
        n_checks++;
        if (err !== 1'b1 || out_ch !== 2'd0 || out_coef !== e_bad) begin
            n_fail++;
            $display("FAIL bad_channel: err=%0b ch=%0d coef=%0d, required err=1 ch=0 coef=%0d", err, out_ch, out_coef, e_bad);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(1'b1, 4'd0, 4'd2, 11'b10, 2'd0, 1'b0);
        send(1'b0, 4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
        wait_beats(21);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_idx !== 6'd0 || out_coef !== 12'sd0 || out_last !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: valid=%0b idx=%0d coef=%0d last=%0b err=%0b, required all 0",
                     out_valid, out_idx, out_coef, out_last, err);
        end
        reset = 1'b0;
        clear_mon();
        send(1'b0, 4'd0, 4'd1, 11'd1, 2'd0, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ac_err: %0b, required 1", err); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (mon_coef.size() !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_dropped: beats=%0d valid=%0b, required beats=0 valid=0", mon_coef.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_dc_eob();
        test_dc_pred();
        test_ac_run();
        test_zrl();
        test_overrun();
        test_backpressure();
        test_dc_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
